// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder sequencer with carry/overflow flags (optional SERIAL_SUB_EN)
module serial_add_ctrl #(
  parameter int P_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
`ifdef SERIAL_SUB_EN
  input  logic               sub,
`endif
  input  logic               a_bit,
  input  logic               b_bit,
  output logic               l_s,
  output logic               busy,
  output logic               done,
  output logic [P_WIDTH-1:0] sum,
  output logic               cout,
  output logic               ovf
);

  localparam int CW = $clog2(P_WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(P_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [P_WIDTH-1:0] acc_q, acc_d;
  logic [P_WIDTH-1:0] sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               l_s_q, l_s_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               b_eff;
  logic               carry_init;
  logic               s_bit;
  logic               c_next;

`ifdef SERIAL_SUB_EN
  logic sub_q, sub_d;
  // Subtraction is A + ~B + 1: invert b and seed the carry with 1.
  assign b_eff      = b_bit ^ sub_q;
  assign carry_init = sub_q;
`else
  assign b_eff      = b_bit;
  assign carry_init = 1'b0;
`endif

  assign s_bit  = a_bit ^ b_eff ^ carry_q;
  assign c_next = (a_bit & b_eff) | (a_bit & carry_q) | (b_eff & carry_q);

  // Next-state, datapath updates and registered output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
`ifdef SERIAL_SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
`ifdef SERIAL_SUB_EN
          sub_d   = sub;
`endif
        end
      end
      LOAD: begin
        carry_d = carry_init;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        acc_d   = {s_bit, acc_q[P_WIDTH-1:1]};
        carry_d = c_next;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          sum_d   = {s_bit, acc_q[P_WIDTH-1:1]};
          cout_d  = c_next;
          // carry_q is the carry into the MSB on this final bit.
          ovf_d   = carry_q ^ c_next;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    l_s_d  = (state_d != LOAD);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      l_s_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      l_s_q   <= l_s_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign l_s  = l_s_q;
  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl with operand shifter models
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub_r = 1'b0;
  logic         a_bit, b_bit;
  logic         l_s, busy, done, cout, ovf;
  logic [W-1:0] sum;

  logic [W-1:0] op_a = '0, op_b = '0;
  logic [W-1:0] sh_a = '0, sh_b = '0;

  int checks = 0;
  int failures = 0;
  int load_cnt = 0;
  int done_cnt = 0;

  serial_add_ctrl #(.P_WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
`ifdef SERIAL_SUB_EN
    .sub   (sub_r),
`endif
    .a_bit (a_bit),
    .b_bit (b_bit),
    .l_s   (l_s),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Operand parallel-to-serial shifters: load when l_s=0, else shift right.
  always @(posedge clk) begin
    if (!l_s) begin
      sh_a <= op_a;
      sh_b <= op_b;
    end else begin
      sh_a <= sh_a >> 1;
      sh_b <= sh_b >> 1;
    end
  end
  assign a_bit = sh_a[0];
  assign b_bit = sh_b[0];

  always @(negedge clk) begin
    if (!rst && !l_s) load_cnt = load_cnt + 1;
    if (!rst && done) done_cnt = done_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic; returns {ovf, cout, sum}.
  function automatic logic [W+1:0] ref_result(input int a, input int b, input bit s);
    int bb, total, res;
    bit c, v;
    bb    = s ? ((~b) & 255) : b;
    total = a + bb + (s ? 1 : 0);
    res   = total & 255;
    c     = (total >= 256);
    v     = (((a >> 7) & 1) == ((bb >> 7) & 1)) && (((res >> 7) & 1) != ((a >> 7) & 1));
    return {v, c, res[W-1:0]};
  endfunction

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
    logic [W+1:0] exp;
    int lat, l0;
    bit got;
    exp = ref_result(int'(a), int'(b), s);
    @(negedge clk);
    op_a = a; op_b = b; sub_r = s; start = 1'b1;
    l0 = load_cnt;
    @(posedge clk);
    #1 start = 1'b0;
    check_eq("accept_busy", busy, 1);
    lat = 0; got = 0;
    while (lat < 20 && !got) begin
      @(posedge clk);
      lat++;
      #1;
      if (done) got = 1;
    end
    check_eq("latency", lat, 9);
    check_eq("sum", sum, exp[W-1:0]);
    check_eq("cout", cout, exp[W]);
    check_eq("ovf", ovf, exp[W+1]);
    check_eq("loads_per_op", load_cnt - l0, 1);
    @(posedge clk);
    #1;
    check_eq("done_one_cycle", done, 0);
    check_eq("idle_busy", busy, 0);
    check_eq("sum_held", sum, exp[W-1:0]);
  endtask

  initial begin
    logic [W+1:0] e;
    int last, l0, d0;
    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_sum", sum, 0);
    check_eq("rst_cout", cout, 0);
    check_eq("rst_ovf", ovf, 0);
    check_eq("rst_l_s", l_s, 1);

    // Directed adds and boundaries
    do_op(8'h35, 8'h4A, 0);
    do_op(8'hFF, 8'h01, 0);
    do_op(8'h7F, 8'h01, 0);
    do_op(8'h80, 8'h80, 0);
    do_op(8'h00, 8'h00, 0);

    // Randomised adds (and subtracts when the feature is built)
    for (int i = 0; i < 16; i++) begin
`ifdef SERIAL_SUB_EN
      do_op(W'($urandom), W'($urandom), bit'($urandom_range(0, 1)));
`else
      do_op(W'($urandom), W'($urandom), 0);
`endif
    end

    // Start held high through three operations
    e = ref_result(8'h5A, 8'h21, 0);
    @(negedge clk);
    op_a = 8'h5A; op_b = 8'h21; sub_r = 0; start = 1'b1;
    l0 = load_cnt; d0 = done_cnt; last = -1;
    for (int k = 0; k < 33; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        if (last < 0) check_eq("b2b_first", k, 9);
        else check_eq("b2b_interval", k - last, 11);
        check_eq("b2b_sum", sum, e[W-1:0]);
        last = k;
      end
    end
    start = 1'b0;
    @(negedge clk);
    check_eq("b2b_dones", done_cnt - d0, 3);
    check_eq("b2b_loads", load_cnt - l0, 3);
    @(posedge clk);
    #1 check_eq("b2b_idle", busy, 0);

    // Reset during the 4th SHIFT cycle
    @(negedge clk);
    op_a = 8'h3C; op_b = 8'h11; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    d0 = done_cnt;
    @(posedge clk);
    #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_sum", sum, 0);
    check_eq("mid_rst_l_s", l_s, 1);
    check_eq("mid_rst_done", done, 0);
    check_eq("mid_rst_cout", cout, 0);
    rst = 1'b0;
    repeat (15) @(posedge clk);
    #1 check_eq("mid_rst_no_done", done_cnt - d0, 0);
    do_op(8'h10, 8'h20, 0);

`ifdef SERIAL_SUB_EN
    do_op(8'h05, 8'h03, 1);
    do_op(8'h03, 8'h05, 1);
    do_op(8'h80, 8'h01, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
